// File: rtl/data_mem_resp.sv
// data_mem_resp
//   Multi-cycle data-memory responder for RV32 loads and stores. It accepts one
//   request over a valid/ready handshake and waits LATENCY cycles. It then
//   accesses an internal byte-addressed RAM and returns a single-cycle response
//   strobe carrying extended load data or an error flag.
//
// Parameters
//   DATA_WIDTH  data bus width (32 for RV32)
//   ADDR_WIDTH  decoded byte-address bits; RAM holds 2**(ADDR_WIDTH-2) words
//   LATENCY     wait cycles between acceptance and access (1..15)
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder idle and able to accept
//   req_we      1 = store, 0 = load
//   req_addr    byte address; bits above ADDR_WIDTH-1 are ignored
//   req_wdata   right-aligned store data
//   req_funct3  RV32 size/sign code
//   resp_valid  one-cycle response strobe
//   resp_rdata  extended load data; 0 for stores, errors and outside a response
//   resp_err    misaligned or illegal request, valid with resp_valid
module data_mem_resp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int          WORDS    = 1 << (ADDR_WIDTH - 2);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0]  IDLE = 2'd0;
  localparam logic [1:0]  WAIT = 2'd1;
  localparam logic [1:0]  RESP = 2'd2;

  // Misaligned halfword/word accesses and any funct3 outside the legal
  // load/store sets are rejected without touching the RAM.
  function automatic logic req_is_bad(input logic       we,
                                      input logic [2:0] f3,
                                      input logic [1:0] a);
    logic illegal;
    logic misaligned;
    if (we) illegal = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
    else    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                 ((f3[1:0] == 2'b10) && (a != 2'b00));
    return illegal || misaligned;
  endfunction

  // Byte-lane enables for a store of size sz at lane offset a.
  function automatic logic [3:0] store_be(input logic [1:0] sz,
                                          input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data onto every lane so the enables alone
  // select the destination bytes.
  function automatic logic [31:0] store_lanes(input logic [1:0]  sz,
                                              input logic [31:0] wd);
    case (sz)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Lane select plus sign/zero extension for loads.
  function automatic logic [31:0] load_ext(input logic [31:0] w,
                                           input logic [1:0]  a,
                                           input logic [2:0]  f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  accept;
  logic                  req_bad;
  logic                  access;
  logic                  do_write;

  logic                  we_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [2:0]            funct3_p0;

  logic [DATA_WIDTH-1:0] mem [0:WORDS-1];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [ADDR_WIDTH-3:0] widx;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] lanes;

  // Upper address bits are intentionally dropped so the RAM aliases.
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid;
  assign req_bad   = req_is_bad(req_we, req_funct3, req_addr[1:0]);
  assign access    = (state == WAIT) && (cnt == 4'd0);
  assign do_write  = rst_n && access && we_p0;

  assign widx      = addr_p0[ADDR_WIDTH-1:2];
  assign rd_word   = mem[widx];
  assign be        = store_be(funct3_p0[1:0], addr_p0[1:0]);
  assign lanes     = store_lanes(funct3_p0[1:0], wdata_p0);

  // Stage p0: request capture at the acceptance edge (data only, no reset).
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0     <= req_we;
      addr_p0   <= req_addr[ADDR_WIDTH-1:0];
      wdata_p0  <= req_wdata;
      funct3_p0 <= req_funct3;
    end
  end

  // RAM write at the access edge; only enabled lanes change.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= lanes[8*i +: 8];
      end
    end
  end

  // Control FSM and registered response outputs. The response fields default
  // to zero every edge so they are only non-zero during the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= we_p0 ? '0 : load_ext(rd_word, addr_p0[1:0], funct3_p0);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
